// File: rtl/coin_ejector.sv
// coin_ejector: pays out quarters, then dimes, then nickels one coin at a time, confirming each drop on the chute sensor.
// Optional macro COIN_SUBSTITUTE_EN: break a coin owed from an empty hopper into smaller coins instead of faulting.
module coin_ejector #(
  parameter int CNT_W     = 9,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2,
  parameter int SENSE_TO  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] quarter_i,
  input  logic [CNT_W-1:0] dime_i,
  input  logic [CNT_W-1:0] nickel_i,
  input  logic             coin_sense,
  input  logic             empty_q,
  input  logic             empty_d,
  input  logic             empty_n,
  output logic             sol_q,
  output logic             sol_d,
  output logic             sol_n,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] rem_q,
  output logic [CNT_W-1:0] rem_d,
  output logic [CNT_W-1:0] rem_n
);

  localparam int T_PG  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int T_MAX = (T_PG > SENSE_TO) ? T_PG : SENSE_TO;
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [1:0] FC_EMPTY = 2'b01;
  localparam logic [1:0] FC_JAM   = 2'b10;

  typedef enum logic [2:0] {
    IDLE, SELECT, PULSE, WAIT_SENSE, GAP, DONE, FAULT
  } state_t;

  typedef enum logic [1:0] {SEL_Q, SEL_D, SEL_N} sel_t;

  state_t          state;
  sel_t            sel;
  logic [TW-1:0]   timer;
  logic            sense_prev;

`ifdef COIN_SUBSTITUTE_EN
  localparam logic [1:0] FC_OVF = 2'b11;

  // Widened sums; the carry bit flags a substitution that would overflow a count.
  logic [CNT_W:0] d_plus2;
  logic [CNT_W:0] n_plus1;
  logic [CNT_W:0] n_plus2;

  assign d_plus2 = {1'b0, rem_d} + (CNT_W+1)'(2);
  assign n_plus1 = {1'b0, rem_n} + (CNT_W+1)'(1);
  assign n_plus2 = {1'b0, rem_n} + (CNT_W+1)'(2);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sel        <= SEL_Q;
      timer      <= '0;
      sense_prev <= 1'b0;
      sol_q      <= 1'b0;
      sol_d      <= 1'b0;
      sol_n      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      rem_q      <= '0;
      rem_d      <= '0;
      rem_n      <= '0;
    end else begin
      sense_prev <= coin_sense;
      done       <= 1'b0;
      case (state)
        IDLE, FAULT: begin
          if (load) begin
            rem_q      <= quarter_i;
            rem_d      <= dime_i;
            rem_n      <= nickel_i;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            busy       <= 1'b1;
            state      <= SELECT;
          end
        end

        SELECT: begin
          timer <= '0;
          if (rem_q != '0) begin
            sel <= SEL_Q;
            if (!empty_q) begin
              sol_q <= 1'b1;
              state <= PULSE;
            end
`ifdef COIN_SUBSTITUTE_EN
            else if (d_plus2[CNT_W] || n_plus1[CNT_W]) begin
              fault      <= 1'b1;
              fault_code <= FC_OVF;
              busy       <= 1'b0;
              state      <= FAULT;
            end else begin
              rem_q <= rem_q - CNT_W'(1);
              rem_d <= d_plus2[CNT_W-1:0];
              rem_n <= n_plus1[CNT_W-1:0];
            end
`else
            else begin
              fault      <= 1'b1;
              fault_code <= FC_EMPTY;
              busy       <= 1'b0;
              state      <= FAULT;
            end
`endif
          end else if (rem_d != '0) begin
            sel <= SEL_D;
            if (!empty_d) begin
              sol_d <= 1'b1;
              state <= PULSE;
            end
`ifdef COIN_SUBSTITUTE_EN
            else if (n_plus2[CNT_W]) begin
              fault      <= 1'b1;
              fault_code <= FC_OVF;
              busy       <= 1'b0;
              state      <= FAULT;
            end else begin
              rem_d <= rem_d - CNT_W'(1);
              rem_n <= n_plus2[CNT_W-1:0];
            end
`else
            else begin
              fault      <= 1'b1;
              fault_code <= FC_EMPTY;
              busy       <= 1'b0;
              state      <= FAULT;
            end
`endif
          end else if (rem_n != '0) begin
            sel <= SEL_N;
            if (!empty_n) begin
              sol_n <= 1'b1;
              state <= PULSE;
            end else begin
              fault      <= 1'b1;
              fault_code <= FC_EMPTY;
              busy       <= 1'b0;
              state      <= FAULT;
            end
          end else begin
            state <= DONE;
          end
        end

        PULSE: begin
          if (timer == TW'(PULSE_CYC - 1)) begin
            sol_q <= 1'b0;
            sol_d <= 1'b0;
            sol_n <= 1'b0;
            timer <= '0;
            state <= WAIT_SENSE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        // Only a fresh rising edge counts, so a sensor stuck high cannot confirm a drop.
        WAIT_SENSE: begin
          if (coin_sense && !sense_prev) begin
            case (sel)
              SEL_Q:   rem_q <= rem_q - CNT_W'(1);
              SEL_D:   rem_d <= rem_d - CNT_W'(1);
              default: rem_n <= rem_n - CNT_W'(1);
            endcase
            timer <= '0;
            state <= GAP;
          end else if (timer == TW'(SENSE_TO - 1)) begin
            fault      <= 1'b1;
            fault_code <= FC_JAM;
            busy       <= 1'b0;
            state      <= FAULT;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        GAP: begin
          if (timer == TW'(GAP_CYC - 1)) begin
            timer <= '0;
            state <= SELECT;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
